// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory bus arbiter and its byte-lane aligner.
package mem_arb_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  function automatic logic is_unsigned_load(input logic [2:0] func3);
    return (func3 == LBU) || (func3 == LHU);
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane logic: store strobes/steering, load extraction/extension,
// and legality (func3 validity plus natural alignment).
module mem_align
  import mem_arb_pkg::*;
(
  input  logic            we,
  input  logic [2:0]      func3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic            legal,
  output logic [3:0]      wstrb,
  output logic [XLEN-1:0] wdata_lane,
  output logic [XLEN-1:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        zext;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    zext     = is_unsigned_load(func3);
  end

  // Unsigned variants exist only for loads, so a store with func3[2] set is illegal.
  always_comb begin
    legal      = 1'b0;
    wstrb      = 4'b0000;
    wdata_lane = wdata;
    rdata_ext  = '0;
    case (func3)
      LB, LBU: begin
        legal = !(we && zext);
        if (we) begin
          wstrb      = 4'b0001 << addr_lo;
          wdata_lane = {4{wdata[7:0]}};
        end else begin
          rdata_ext = zext ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        end
      end
      LH, LHU: begin
        legal = !addr_lo[0] && !(we && zext);
        if (we) begin
          wstrb      = 4'b0011 << addr_lo;
          wdata_lane = {2{wdata[15:0]}};
        end else begin
          rdata_ext = zext ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
        end
      end
      LW: begin
        legal = (addr_lo == 2'b00);
        if (we) begin
          wstrb = 4'b1111;
        end else begin
          rdata_ext = rdata;
        end
      end
      default: begin
        legal = 1'b0;
      end
    endcase
    if (!legal) begin
      wstrb     = 4'b0000;
      rdata_ext = '0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-bus arbiter between instruction fetch and the data port: one transfer at a time,
// data has priority, fetch is protected from starvation by a saturating grant counter.
module mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_addr_i,
  output logic            if_ack_o,
  output logic [XLEN-1:0] if_rdata_o,
  input  logic            d_req_i,
  input  logic            d_we_i,
  input  logic [XLEN-1:0] d_addr_i,
  input  logic [XLEN-1:0] d_wdata_i,
  input  logic [2:0]      d_func3_i,
  output logic            d_ack_o,
  output logic [XLEN-1:0] d_rdata_o,
  output logic            d_err_o,
  output logic            bus_req_o,
  output logic            bus_we_o,
  output logic [XLEN-1:0] bus_addr_o,
  output logic [XLEN-1:0] bus_wdata_o,
  output logic [3:0]      bus_wstrb_o,
  input  logic            bus_ack_i,
  input  logic [XLEN-1:0] bus_rdata_i
);
  import mem_arb_pkg::*;

  localparam int              CW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]   STARVE_MAX = CW'(STARVE_LIMIT);
  localparam logic [XLEN-1:0] WORD_MASK  = ~(XLEN'(3));

  state_t          state_reg, state_next;
  logic [CW-1:0]   starve_reg, starve_next;
  logic            grant_d_reg, grant_d_next;
  logic            we_reg, we_next;
  logic [2:0]      func3_reg, func3_next;
  logic [1:0]      lo_reg, lo_next;

  logic            bus_req_reg, bus_req_next;
  logic            bus_we_reg, bus_we_next;
  logic [XLEN-1:0] bus_addr_reg, bus_addr_next;
  logic [XLEN-1:0] bus_wdata_reg, bus_wdata_next;
  logic [3:0]      bus_wstrb_reg, bus_wstrb_next;
  logic            if_ack_reg, if_ack_next;
  logic [XLEN-1:0] if_rdata_reg, if_rdata_next;
  logic            d_ack_reg, d_ack_next;
  logic [XLEN-1:0] d_rdata_reg, d_rdata_next;
  logic            d_err_reg, d_err_next;

  logic            al_we;
  logic [2:0]      al_func3;
  logic [1:0]      al_lo;
  logic            al_legal;
  logic [3:0]      al_wstrb;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_rdata;
  logic            d_win;

  // Live request fields drive the aligner while arbitrating; the captured ones while on the bus.
  always_comb begin
    al_we    = (state_reg == IDLE) ? d_we_i         : we_reg;
    al_func3 = (state_reg == IDLE) ? d_func3_i      : func3_reg;
    al_lo    = (state_reg == IDLE) ? d_addr_i[1:0]  : lo_reg;
  end

  mem_align u_align (
    .we         (al_we),
    .func3      (al_func3),
    .addr_lo    (al_lo),
    .wdata      (d_wdata_i),
    .rdata      (bus_rdata_i),
    .legal      (al_legal),
    .wstrb      (al_wstrb),
    .wdata_lane (al_wdata),
    .rdata_ext  (al_rdata)
  );

  always_comb begin
    state_next     = state_reg;
    starve_next    = starve_reg;
    grant_d_next   = grant_d_reg;
    we_next        = we_reg;
    func3_next     = func3_reg;
    lo_next        = lo_reg;
    bus_req_next   = bus_req_reg;
    bus_we_next    = bus_we_reg;
    bus_addr_next  = bus_addr_reg;
    bus_wdata_next = bus_wdata_reg;
    bus_wstrb_next = bus_wstrb_reg;
    if_ack_next    = 1'b0;
    if_rdata_next  = if_rdata_reg;
    d_ack_next     = 1'b0;
    d_rdata_next   = d_rdata_reg;
    d_err_next     = 1'b0;
    d_win          = d_req_i && !((starve_reg == STARVE_MAX) && if_req_i);

    case (state_reg)
      IDLE: begin
        if (!if_req_i) begin
          starve_next = '0;
        end
        if (d_win) begin
          grant_d_next = 1'b1;
          we_next      = d_we_i;
          func3_next   = d_func3_i;
          lo_next      = d_addr_i[1:0];
          if (!al_legal) begin
            // Rejected without a bus cycle; the starvation count is left alone.
            state_next   = RESP;
            d_ack_next   = 1'b1;
            d_err_next   = 1'b1;
            d_rdata_next = '0;
          end else begin
            state_next     = BUS;
            bus_req_next   = 1'b1;
            bus_we_next    = d_we_i;
            bus_addr_next  = d_addr_i & WORD_MASK;
            bus_wdata_next = d_we_i ? al_wdata : '0;
            bus_wstrb_next = d_we_i ? al_wstrb : 4'b0000;
            if (if_req_i && (starve_reg != STARVE_MAX)) begin
              starve_next = starve_reg + 1'b1;
            end
          end
        end else if (if_req_i) begin
          grant_d_next   = 1'b0;
          state_next     = BUS;
          bus_req_next   = 1'b1;
          bus_we_next    = 1'b0;
          bus_addr_next  = if_addr_i & WORD_MASK;
          bus_wdata_next = '0;
          bus_wstrb_next = 4'b0000;
          starve_next    = '0;
        end
      end
      BUS: begin
        if (bus_ack_i) begin
          state_next     = RESP;
          bus_req_next   = 1'b0;
          bus_we_next    = 1'b0;
          bus_addr_next  = '0;
          bus_wdata_next = '0;
          bus_wstrb_next = 4'b0000;
          if (grant_d_reg) begin
            d_ack_next   = 1'b1;
            d_rdata_next = we_reg ? '0 : al_rdata;
          end else begin
            if_ack_next   = 1'b1;
            if_rdata_next = bus_rdata_i;
          end
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      starve_reg    <= '0;
      grant_d_reg   <= 1'b0;
      we_reg        <= 1'b0;
      func3_reg     <= 3'b000;
      lo_reg        <= 2'b00;
      bus_req_reg   <= 1'b0;
      bus_we_reg    <= 1'b0;
      bus_addr_reg  <= '0;
      bus_wdata_reg <= '0;
      bus_wstrb_reg <= 4'b0000;
      if_ack_reg    <= 1'b0;
      if_rdata_reg  <= '0;
      d_ack_reg     <= 1'b0;
      d_rdata_reg   <= '0;
      d_err_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      starve_reg    <= starve_next;
      grant_d_reg   <= grant_d_next;
      we_reg        <= we_next;
      func3_reg     <= func3_next;
      lo_reg        <= lo_next;
      bus_req_reg   <= bus_req_next;
      bus_we_reg    <= bus_we_next;
      bus_addr_reg  <= bus_addr_next;
      bus_wdata_reg <= bus_wdata_next;
      bus_wstrb_reg <= bus_wstrb_next;
      if_ack_reg    <= if_ack_next;
      if_rdata_reg  <= if_rdata_next;
      d_ack_reg     <= d_ack_next;
      d_rdata_reg   <= d_rdata_next;
      d_err_reg     <= d_err_next;
    end
  end

  assign bus_req_o   = bus_req_reg;
  assign bus_we_o    = bus_we_reg;
  assign bus_addr_o  = bus_addr_reg;
  assign bus_wdata_o = bus_wdata_reg;
  assign bus_wstrb_o = bus_wstrb_reg;
  assign if_ack_o    = if_ack_reg;
  assign if_rdata_o  = if_rdata_reg;
  assign d_ack_o     = d_ack_reg;
  assign d_rdata_o   = d_rdata_reg;
  assign d_err_o     = d_err_reg;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port bus arbiter sharing the core's single memory bus between instruction fetch and the data side driven by `exe`'s `mem_re_o`/`mem_we_o`/`mem_addr_o`/`opfunc3_o`. It serialises one transfer at a time and gives the data port priority, with a starvation guard for fetch. It performs byte-lane steering for stores and sign/zero extension for loads, and flags misaligned or illegal accesses without touching the bus.

## Interface
- `XLEN`, 32: data/address width; the byte-lane logic assumes 32.
- `STARVE_LIMIT`, 4: consecutive data grants allowed while fetch is pending.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `if_req_i` in 1: fetch request, held until `if_ack_o`.
- `if_addr_i` in XLEN: fetch address, word-aligned, stable while requesting.
- `if_ack_o` out 1: one-cycle completion pulse.
- `if_rdata_o` out XLEN: fetched word, valid with `if_ack_o`.
- `d_req_i` in 1: data request, held until `d_ack_o`.
- `d_we_i` in 1: 1 = store, 0 = load.
- `d_addr_i` in XLEN: byte address.
- `d_wdata_i` in XLEN: store data, LSB-justified.
- `d_func3_i` in 3: RV32 load/store func3.
- `d_ack_o` out 1: one-cycle completion pulse.
- `d_rdata_o` out XLEN: extended load data, valid with `d_ack_o`; 0 for stores and errors.
- `d_err_o` out 1: misaligned or illegal func3, valid with `d_ack_o`.
- `bus_req_o` out 1: bus request.
- `bus_we_o` out 1: bus write.
- `bus_addr_o` out XLEN: word address, `[1:0]` = 0.
- `bus_wdata_o` out XLEN: lane-steered store data.
- `bus_wstrb_o` out 4: byte enables; 0 on reads.
- `bus_ack_i` in 1: bus completion; `bus_rdata_i` is valid in the same cycle.
- `bus_rdata_i` in XLEN: bus read word.

## Operation
- FSM states:
  - IDLE: arbitrate among sampled requests.
  - BUS: hold bus outputs stable until `bus_ack_i`.
  - RESP: assert the granted port's ack for one cycle, then return to IDLE.
- Arbitration in IDLE:
  - With `d_req_i` set, data wins unless the starvation count equals `STARVE_LIMIT` and `if_req_i` is set; in that case fetch wins.
  - Otherwise fetch wins if `if_req_i` is set.
  - With no request, stay in IDLE.
- Starvation counter:
  - Increments on each data grant while `if_req_i` is high.
  - Clears on a fetch grant or whenever `if_req_i` is low in IDLE.
  - Saturates at `STARVE_LIMIT`.
- Data legality, decided in IDLE:
  - Loads: func3 000/100 (byte), 001/101 (half), 010 (word) are legal. Stores: 000/001/010 only.
  - Half requires `addr[0]`=0; word requires `addr[1:0]`=0.
  - An illegal access goes IDLE→RESP directly with `d_err_o`=1. No bus cycle is issued, and the starvation counter is unchanged.
- Store steering:
  - Byte: `wdata[7:0]` is replicated to all lanes; strobe is `4'b0001<<addr[1:0]`.
  - Half: `wdata[15:0]` is placed in both halves; strobe is `4'b0011<<addr[1:0]`.
  - Word: strobe is `4'b1111`.
- Load extraction: select the byte or half at `addr[1:0]`. func3 000/001 sign-extend; 100/101 zero-extend.
- Response capture: `bus_rdata_i` is captured on `bus_ack_i`; the processed value is registered into the response register for RESP.
- Requester rules:
  - A requester must hold its request and inputs from assertion through its ack cycle.
  - A request still high in the cycle after ack is a new back-to-back transfer.
- In BUS:
  - A dropped request is ignored; the transfer completes and is still acked.
  - `bus_ack_i` outside BUS is ignored.
- Fetch uses `if_addr_i` with `[1:0]` forced to 0, `bus_we_o`=0 and strobe 0.

## Timing
- All outputs are registered.
- Reset (async, immediate) drives state to IDLE, every output to 0 and the starvation counter to 0. Reset mid-BUS abandons the bus transfer; the bus slave must tolerate `bus_req_o` dropping.
- Request sampled in IDLE at cycle 0:
  - `bus_req_o`=1 from cycle 1.
  - `bus_ack_i` arrives at cycle k≥1.
  - `bus_req_o`=0 and port ack=1 at cycle k+1.
  - IDLE at cycle k+2.
  - Minimum turnaround is 3 cycles per transfer.
- Error path: ack at cycle 1, no bus activity.
- `if_ack_o` and `d_ack_o` are never high together.

## Structure
- Package `mem_arb_pkg`: FSM state enum (IDLE/BUS/RESP), func3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW), `XLEN`.
- Sub-module `mem_align` (combinational): produces strobe, steered write data, legality flag and extended read data from func3, `addr[1:0]`, `wdata` and `rdata`. Shared with any future LSU.

## Test plan
- Fetch only, `bus_ack_i` one cycle after `bus_req_o`, `bus_rdata_i`=0x00000013 -> `if_ack_o` at cycle 3 with `if_rdata_o`=0x00000013; `bus_wstrb_o`=0.
- LB at addr 0x103, `bus_rdata_i`=0x80AABBCC -> `bus_addr_o`=0x100, `d_rdata_o`=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH at addr 0x202, `d_wdata_i`=0x1234ABCD -> `bus_wstrb_o`=0b1100, `bus_wdata_o`=0xABCDABCD, `bus_addr_o`=0x200.
- LW at addr 0x101 -> `d_ack_o`=1 and `d_err_o`=1 at cycle 1; `bus_req_o` stays 0.
- `if_req_i` and `d_req_i` held continuously, `STARVE_LIMIT`=4 -> grant order D,D,D,D,I,D,D,D,D,I.
- Assert `rst_i` mid-BUS with `bus_ack_i` low -> all outputs 0 immediately. After release, a new fetch completes normally.
